systolic_skew_feeder: RTL and testbench

// - Upstream feeder for SystolicArray: latches operand matrices A (NxN) and B (NxN) on a start pulse.
// - Emits diagonally skewed west/north operand streams and drives accumulate_enable for the full compute window.
// - Raises done when the array holds C = A*B.
// - Replaces per-lane FIFO loading and manual staggered bubble sequencing with one FSM.

---
 rtl/systolic_skew_feeder_pkg.sv | 21 ++
 rtl/systolic_skew_feeder_skew_lane_select.sv | 26 ++
 rtl/systolic_skew_feeder.sv | 130 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and helpers for the systolic skew feeder and the array it feeds.
// The state set includes FeedClear, used only when SYSTOLIC_FEEDER_CLEAR_EN is defined.
package systolic_skew_feeder_pkg;

  localparam int unsigned DefaultArraySize = 4;
  localparam int unsigned DefaultDataWidth = 16;

  typedef enum logic [1:0] {
    FeedIdle   = 2'd0,
    FeedClear  = 2'd1,
    FeedStream = 2'd2,
    FeedDone   = 2'd3
  } feed_state_e;

  // Bit offset of element [row][col] in a row-major packed n x n matrix, element [0][0] in MSBs.
  function automatic int unsigned elem_offset(input int unsigned n, input int unsigned w,
                                              input int unsigned row, input int unsigned col);
    return (n * n - 1 - (row * n + col)) * w;
  endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane_select.sv
// Picks element [t - lane] of one latched row/column, or 0 outside the lane's active window.
module skew_lane_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 16,
  parameter int unsigned TW = $clog2(3 * N)
) (
  input  logic [TW-1:0]  t,
  input  logic [TW-1:0]  lane,
  input  logic [N*W-1:0] vec,
  output logic [W-1:0]   elem
);

  logic [TW-1:0] k;

  always_comb begin
    elem = '0;
    k    = t - lane;
    // Guarding on t >= lane keeps the unsigned difference from wrapping into a valid index.
    if (t >= lane) begin
      for (int unsigned e = 0; e < N; e++) begin
        if (k == TW'(e)) elem = vec[(N-1-e)*W +: W];
      end
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Latches A/B on start and streams diagonally skewed operands into a systolic array.
// Defining SYSTOLIC_FEEDER_CLEAR_EN adds an array_clear pulse and a CLEAR state before STREAM.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int unsigned ARRAY_SIZE = DefaultArraySize,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0]  a_matrix,
  input  logic [ARRAY_SIZE*ARRAY_SIZE*DATA_WIDTH-1:0]  b_matrix,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         accumulate_enable,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             west_inputs,
  output logic [ARRAY_SIZE*DATA_WIDTH-1:0]             north_inputs
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
  ,
  output logic                                         array_clear
`endif
);

  localparam int unsigned N  = ARRAY_SIZE;
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned TW = $clog2(3 * N);
  localparam logic [TW-1:0] LastT = TW'(3 * N - 2);

  feed_state_e       state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [N*N*W-1:0]  a_q, a_d, b_q, b_d;
  logic [N*W-1:0]    west_sel, north_sel, west_d, north_d;
  logic              busy_d, done_d, acc_d, stream_d;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      FeedIdle: begin
        if (start) begin
          a_d = a_matrix;
          b_d = b_matrix;
          t_d = '0;
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
          state_d = FeedClear;
`else
          state_d = FeedStream;
`endif
        end
      end
      FeedClear: state_d = FeedStream;
      FeedStream: begin
        if (t_q == LastT) state_d = FeedDone;
        else              t_d = t_q + 1'b1;
      end
      FeedDone: state_d = FeedIdle;
      default:  state_d = FeedIdle;
    endcase
  end

  // Lanes are computed from next-state values so the registered outputs line up with t.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N*W-1:0] col;
    logic [W-1:0]   west_elem, north_elem;

    for (genvar k = 0; k < N; k++) begin : g_col
      assign col[(N-1-k)*W +: W] = b_d[elem_offset(N, W, k, i) +: W];
    end

    skew_lane_select #(.N(N), .W(W), .TW(TW)) u_west (
      .t    (t_d),
      .lane (TW'(i)),
      .vec  (a_d[elem_offset(N, W, i, N - 1) +: N*W]),
      .elem (west_elem)
    );

    skew_lane_select #(.N(N), .W(W), .TW(TW)) u_north (
      .t    (t_d),
      .lane (TW'(i)),
      .vec  (col),
      .elem (north_elem)
    );

    assign west_sel[(N-1-i)*W +: W]  = west_elem;
    assign north_sel[(N-1-i)*W +: W] = north_elem;
  end

  always_comb begin
    stream_d = (state_d == FeedStream);
    busy_d   = stream_d || (state_d == FeedClear);
    done_d   = (state_d == FeedDone);
    acc_d    = stream_d;
    west_d   = stream_d ? west_sel : '0;
    north_d  = stream_d ? north_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= FeedIdle;
      t_q               <= '0;
      a_q               <= '0;
      b_q               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      accumulate_enable <= 1'b0;
      west_inputs       <= '0;
      north_inputs      <= '0;
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
      array_clear       <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      t_q               <= t_d;
      a_q               <= a_d;
      b_q               <= b_d;
      busy              <= busy_d;
      done              <= done_d;
      accumulate_enable <= acc_d;
      west_inputs       <= west_d;
      north_inputs      <= north_d;
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
      array_clear       <= (state_d == FeedClear);
`endif
    end
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Randomized bench for systolic_skew_feeder: lane streams against the skew rule and an
// array-level product model; also covers SYSTOLIC_FEEDER_CLEAR_EN when defined.
module tb_systolic_skew_feeder;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int TMAX = 3 * N - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [N*N*W-1:0] a_matrix = '0;
  logic [N*N*W-1:0] b_matrix = '0;
  logic             busy, done, accumulate_enable;
  logic [N*W-1:0]   west_inputs, north_inputs;
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
  logic             array_clear;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned ma [N][N];
  int unsigned mb [N][N];
  logic [W-1:0] west_h  [TMAX][N];
  logic [W-1:0] north_h [TMAX][N];
  logic [W-1:0] c_model [N][N];

  localparam logic [15:0] SpecA [16] = '{16'h0022, 16'h008d, 16'h000c, 16'h009e,
                                         16'h009d, 16'h00cb, 16'h007a, 16'h006d,
                                         16'h007d, 16'h0034, 16'h009b, 16'h000b,
                                         16'h00ca, 16'h0089, 16'h0026, 16'h0065};
  localparam logic [15:0] SpecB [16] = '{16'h0099, 16'h00bd, 16'h002a, 16'h00a5,
                                         16'h0087, 16'h0070, 16'h000f, 16'h0078,
                                         16'h0055, 16'h00bf, 16'h006d, 16'h0043,
                                         16'h00ad, 16'h0091, 16'h003c, 16'h00e4};
  localparam logic [15:0] SpecRow0 [4] = '{16'hcd6f, 16'hb93c, 16'h37fb, 16'he7de};

  systolic_skew_feeder #(.ARRAY_SIZE(N), .DATA_WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .a_matrix          (a_matrix),
    .b_matrix          (b_matrix),
    .busy              (busy),
    .done              (done),
    .accumulate_enable (accumulate_enable),
    .west_inputs       (west_inputs),
    .north_inputs      (north_inputs)
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
    ,
    .array_clear       (array_clear)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*N*W-1:0] pack_mat(input bit sel_b);
    logic [N*N*W-1:0] m = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        m[(N*N-1-(r*N+c))*W +: W] = W'(sel_b ? mb[r][c] : ma[r][c]);
    return m;
  endfunction

  function automatic logic [N*W-1:0] exp_west(input int t);
    logic [N*W-1:0] v = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) v[(N-1-i)*W +: W] = W'(ma[i][t-i]);
    return v;
  endfunction

  function automatic logic [N*W-1:0] exp_north(input int t);
    logic [N*W-1:0] v = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) v[(N-1-j)*W +: W] = W'(mb[t-j][j]);
    return v;
  endfunction

  function automatic logic [N*N*W-1:0] rand_bus();
    logic [N*N*W-1:0] v;
    for (int i = 0; i < N*N*W/32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic randomize_mats();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = $urandom_range(0, 16'hffff);
        mb[r][c] = $urandom_range(0, 16'hffff);
      end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_acc"}, 64'(accumulate_enable), 64'd0);
    check({tag, "_west"}, 64'(west_inputs), 64'd0);
    check({tag, "_north"}, 64'(north_inputs), 64'd0);
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
    check({tag, "_clear"}, 64'(array_clear), 64'd0);
`endif
  endtask

  // One multiply; abort_t >= 0 pulls reset during that stream cycle, glitch pokes start mid-run.
  task automatic run_op(input int abort_t, input bit glitch);
    a_matrix = pack_mat(1'b0);
    b_matrix = pack_mat(1'b1);
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    a_matrix = rand_bus();
    b_matrix = rand_bus();
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
    check("clear_pulse", 64'(array_clear), 64'd1);
    check("clear_acc", 64'(accumulate_enable), 64'd0);
    check("clear_busy", 64'(busy), 64'd1);
    check("clear_west", 64'(west_inputs), 64'd0);
    @(posedge clk); #1;
`endif
    for (int t = 0; t < TMAX; t++) begin
      check($sformatf("acc_t%0d", t), 64'(accumulate_enable), 64'd1);
      check($sformatf("busy_t%0d", t), 64'(busy), 64'd1);
      check($sformatf("done_t%0d", t), 64'(done), 64'd0);
      check($sformatf("west_t%0d", t), 64'(west_inputs), 64'(exp_west(t)));
      check($sformatf("north_t%0d", t), 64'(north_inputs), 64'(exp_north(t)));
`ifdef SYSTOLIC_FEEDER_CLEAR_EN
      check($sformatf("clear_t%0d", t), 64'(array_clear), 64'd0);
`endif
      for (int l = 0; l < N; l++) begin
        west_h[t][l]  = west_inputs[(N-1-l)*W +: W];
        north_h[t][l] = north_inputs[(N-1-l)*W +: W];
      end
      if (t == abort_t) begin
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_quiet("abort");
        for (int c = 0; c < TMAX + 2; c++) begin
          @(posedge clk); #1;
          check("abort_no_done", 64'(done), 64'd0);
          check("abort_busy", 64'(busy), 64'd0);
        end
        return;
      end
      start = glitch && (t == 2);
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_pulse", 64'(done), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_acc", 64'(accumulate_enable), 64'd0);
    check("done_west", 64'(west_inputs), 64'd0);
    check("done_north", 64'(north_inputs), 64'd0);
    start = glitch;
    @(posedge clk); #1;
    start = 1'b0;
    check_quiet("after_done");
    @(posedge clk); #1;
    check_quiet("idle");
    // PE(i,j) sees west lane i delayed j cycles and north lane j delayed i cycles.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int unsigned s = 0;
        int unsigned r = 0;
        for (int t = 0; t < TMAX; t++)
          if (t >= i && t >= j)
            s += int'(west_h[t-j][i]) * int'(north_h[t-i][j]);
        for (int k = 0; k < N; k++) r += ma[i][k] * mb[k][j];
        c_model[i][j] = s[W-1:0];
        check($sformatf("c%0d%0d", i, j), 64'(c_model[i][j]), 64'(r[W-1:0]));
      end
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_quiet("reset");
    end
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check_quiet("post_reset");

    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        ma[r][c] = SpecA[r*N+c];
        mb[r][c] = SpecB[r*N+c];
      end
    run_op(-1, 1'b1);
    for (int j = 0; j < N; j++)
      check($sformatf("spec_row0_%0d", j), 64'(c_model[0][j]), 64'(SpecRow0[j]));

    randomize_mats();
    run_op(5, 1'b0);
    run_op(-1, 1'b0);

    repeat (4) begin
      randomize_mats();
      run_op(-1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
